// File: rtl/mips_pkg.sv
// Shared register-file types and constants for the writeback queue.
package mips_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] reg_idx;
        logic [DATA_W-1:0]    data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search of the queued writes for one forwarding lookup port.
module wb_fwd_match
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  wb_entry_t [DEPTH-1:0] entries_i,
    input  logic [AW-1:0]         wr_ptr_i,
    input  logic [REG_IDX_W-1:0]  lk_reg_i,
    output logic                  hit_o,
    output logic [DATA_W-1:0]     data_o
);

    logic [AW-1:0] idx_s;

    // Walk oldest to youngest so a later (younger) match overrides an older one.
    always_comb begin
        hit_o  = 1'b0;
        data_o = {DATA_W{1'b0}};
        idx_s  = {AW{1'b0}};
        for (int i = DEPTH; i >= 1; i--) begin
            idx_s = wr_ptr_i - AW'(i);
            if (entries_i[idx_s].valid && (entries_i[idx_s].reg_idx == lk_reg_i) &&
                (lk_reg_i != REG_ZERO)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx_s].data;
            end else begin
                hit_o  = hit_o;
                data_o = data_o;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// In-order writeback queue that drains onto the register file write port
// and forwards still-queued results to two decode lookup ports.
module regfile_wb_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] in_reg,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 wb_hold,
    output logic                 RegWriteSig,
    output logic [REG_IDX_W-1:0] writeReg,
    output logic [DATA_W-1:0]    writeData,
    input  logic [REG_IDX_W-1:0] lk_reg1,
    input  logic [REG_IDX_W-1:0] lk_reg2,
    output logic                 lk_hit1,
    output logic                 lk_hit2,
    output logic [DATA_W-1:0]    lk_data1,
    output logic [DATA_W-1:0]    lk_data2,
    output logic [AW:0]          count
);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    wb_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  empty_s, store_s, pop_s;

    assign empty_s     = (count_q == {(AW+1){1'b0}});
    assign in_ready    = (count_q != CNT_FULL);
    // r0 pushes complete the handshake but never occupy an entry.
    assign store_s     = in_valid && in_ready && (in_reg != REG_ZERO);
    assign pop_s       = !empty_s && !wb_hold;
    assign RegWriteSig = pop_s;
    assign writeReg    = empty_s ? REG_ZERO : entries_q[rd_ptr_q].reg_idx;
    assign writeData   = empty_s ? {DATA_W{1'b0}} : entries_q[rd_ptr_q].data;
    assign count       = count_q;

    // Next-state for entry array, pointers and occupancy.
    always_comb begin
        entries_d = entries_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (pop_s) begin
            entries_d[rd_ptr_q].valid = 1'b0;
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (store_s) begin
            entries_d[wr_ptr_q] = {1'b1, in_reg, in_data};
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (store_s && !pop_s) begin
            count_d = count_q + CNT_ONE;
        end else if (!store_s && pop_s) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // State registers with asynchronous discard of all queued writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries_q <= '0;
            wr_ptr_q  <= {AW{1'b0}};
            rd_ptr_q  <= {AW{1'b0}};
            count_q   <= {(AW+1){1'b0}};
        end else begin
            entries_q <= entries_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    wb_fwd_match #(.DEPTH(DEPTH), .AW(AW)) u_fwd1 (
        .entries_i (entries_q),
        .wr_ptr_i  (wr_ptr_q),
        .lk_reg_i  (lk_reg1),
        .hit_o     (lk_hit1),
        .data_o    (lk_data1)
    );

    wb_fwd_match #(.DEPTH(DEPTH), .AW(AW)) u_fwd2 (
        .entries_i (entries_q),
        .wr_ptr_i  (wr_ptr_q),
        .lk_reg_i  (lk_reg2),
        .hit_o     (lk_hit2),
        .data_o    (lk_data2)
    );

endmodule
